seg7_result_decoder: RTL

- Receive-side counterpart of the ALU result display encoder. Takes the 8-bit seven-segment pattern and the error LED (LED[7]) and turns them back into a signed result with overflow/underflow/invalid flags.
- Filters glitches: a pattern is accepted only after it is stable for a set number of cycles. Emits one valid pulse per accepted change and keeps event counters.
- Used for loopback checking of the display path and for lcd_* debug readout in top-level experiments.

---
 rtl/seg7_result_decoder_if.sv | 24 ++
 rtl/seg7_result_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seg7_result_decoder_if.sv
// rtl/seg7_result_decoder_if.sv - display pattern in, decoded result/flags/counters out
interface seg7_result_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       seg_i;
  logic             err_i;
  logic [3:0]       val_o;
  logic             ovf_o;
  logic             unf_o;
  logic             inv_o;
  logic             valid_o;
  logic [CNT_W-1:0] cnt_ok_o;
  logic [CNT_W-1:0] cnt_err_o;

  modport master (
    output seg_i, err_i,
    input  val_o, ovf_o, unf_o, inv_o, valid_o, cnt_ok_o, cnt_err_o
  );

  modport slave (
    input  seg_i, err_i,
    output val_o, ovf_o, unf_o, inv_o, valid_o, cnt_ok_o, cnt_err_o
  );
endinterface

// File: rtl/seg7_result_decoder.sv
// rtl/seg7_result_decoder.sv - debounced seven-segment/LED decoder to signed result; SEG7_DEC_STATS_EN enables event counters
module seg7_result_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  seg7_result_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

  state_t     state;
  logic [8:0] cur;
  logic [8:0] samp;
  logic [8:0] last;
  logic       have_last;
  logic [7:0] stab_cnt;

  logic [3:0] val_q;
  logic       ovf_q, unf_q, inv_q, valid_q;

  logic [2:0] digit;
  logic       digit_ok;
  logic [3:0] dec_val;
  logic       dec_ovf, dec_unf, dec_inv;

  assign cur = {bus.err_i, bus.seg_i};

  // Previous-sample register; the FSM compares the live input against it.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) samp <= '0;
    else          samp <= cur;
  end

  // Decode the settled code held in samp into value and flags.
  always_comb begin
    digit    = 3'd0;
    digit_ok = 1'b1;
    dec_val  = 4'd0;
    dec_ovf  = 1'b0;
    dec_unf  = 1'b0;
    dec_inv  = 1'b0;
    case (samp[6:0])
      7'b0111111: digit = 3'd0;
      7'b0000110: digit = 3'd1;
      7'b1011011: digit = 3'd2;
      7'b1001111: digit = 3'd3;
      7'b1100110: digit = 3'd4;
      default:    digit_ok = 1'b0;
    endcase
    if (samp[8]) begin
      if (samp[7:0] == 8'b00111111)      dec_ovf = 1'b1;
      else if (samp[7:0] == 8'b00111110) dec_unf = 1'b1;
      else                               dec_inv = 1'b1;
    end else if (!digit_ok || (!samp[7] && digit == 3'd4) || (samp[7] && digit == 3'd0)) begin
      dec_inv = 1'b1;
    end else begin
      dec_val = samp[7] ? (4'd0 - {1'b0, digit}) : {1'b0, digit};
    end
  end

  // Stability FSM: qualify a new code, then register it and pulse valid for one cycle.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stab_cnt  <= 8'd0;
      last      <= 9'd0;
      have_last <= 1'b0;
      val_q     <= 4'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inv_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!have_last || cur != last) begin
            state    <= SETTLE;
            stab_cnt <= 8'd1;
          end
        end
        SETTLE: begin
          if (have_last && cur == last) begin
            state <= IDLE;
          end else if (cur != samp) begin
            stab_cnt <= 8'd1;
          end else begin
            stab_cnt <= stab_cnt + 8'd1;
            if (stab_cnt == LAST_COUNT) state <= EMIT;
          end
        end
        EMIT: begin
          val_q     <= dec_val;
          ovf_q     <= dec_ovf;
          unf_q     <= dec_unf;
          inv_q     <= dec_inv;
          valid_q   <= 1'b1;
          last      <= samp;
          have_last <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.val_o   = val_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.unf_o   = unf_q;
  assign bus.inv_o   = inv_q;
  assign bus.valid_o = valid_q;

`ifdef SEG7_DEC_STATS_EN
  logic [CNT_W-1:0] cnt_ok_q;
  logic [CNT_W-1:0] cnt_err_q;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters, one increment per accepted code.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (state == EMIT) begin
      if (dec_ovf || dec_unf || dec_inv) begin
        if (cnt_err_q != '1) cnt_err_q <= cnt_err_q + ONE;
      end else begin
        if (cnt_ok_q != '1) cnt_ok_q <= cnt_ok_q + ONE;
      end
    end
  end

  assign bus.cnt_ok_o  = cnt_ok_q;
  assign bus.cnt_err_o = cnt_err_q;
`else
  assign bus.cnt_ok_o  = '0;
  assign bus.cnt_err_o = '0;
`endif

endmodule
